// File: rtl/edn_pkg.sv
// rtl/edn_pkg.sv - EDN endpoint request/response types and bus widths
//
// Purpose: shared types for the EDN endpoint interface.
//   edn_req_t : consumer -> EDN, single edn_req bit.
//   edn_rsp_t : EDN -> consumer, edn_ack pulse, edn_fips tag, edn_bus word.

package edn_pkg;

  localparam int ENDPOINT_BUS_WIDTH = 32;
  localparam int GENBITS_BUS_WIDTH  = 128;

  typedef struct packed {
    logic edn_req;
  } edn_req_t;

  typedef struct packed {
    logic                          edn_ack;
    logic                          edn_fips;
    logic [ENDPOINT_BUS_WIDTH-1:0] edn_bus;
  } edn_rsp_t;

endpackage

// File: rtl/edn_ep_responder.sv
// rtl/edn_ep_responder.sv - EDN endpoint responder: buffers one 128-bit block, serves four 32-bit words
//
// Purpose: responder side of one EDN endpoint. Captures one generated-bits
// block from upstream and hands it to the consumer as four words, LSW first,
// one single-cycle ack per word (never two acks back to back).
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   enable_i         endpoint enable; low flushes the buffer and blocks acks
//   genbits_valid_i  upstream block valid
//   genbits_ready_o  upstream block ready (enable & buffer empty)
//   genbits_i        upstream 128-bit entropy block
//   genbits_fips_i   FIPS tag of the upstream block
//   edn_i            consumer request
//   edn_o            ack / fips / bus response (bus and fips zero outside ack)
//   words_served_o   saturating count of acked words, cleared only by reset

module edn_ep_responder
  import edn_pkg::*;
#(
  parameter int CntWidth = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         genbits_valid_i,
  output logic                         genbits_ready_o,
  input  logic [GENBITS_BUS_WIDTH-1:0] genbits_i,
  input  logic                         genbits_fips_i,
  input  edn_req_t                     edn_i,
  output edn_rsp_t                     edn_o,
  output logic [CntWidth-1:0]          words_served_o
);

  localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

  // buf_valid_q is the whole FSM state: 0 = StEmpty, 1 = StFull.
  logic [GENBITS_BUS_WIDTH-1:0]  buf_q,       buf_d;
  logic                          fips_q,      fips_d;
  logic                          buf_valid_q, buf_valid_d;
  logic [1:0]                    idx_q,       idx_d;
  logic                          ack_q;
  logic [ENDPOINT_BUS_WIDTH-1:0] bus_q,       bus_d;
  logic                          bus_fips_q,  bus_fips_d;
  logic [CntWidth-1:0]           cnt_q,       cnt_d;

  logic w_handshake;
  logic w_ack_d;

  assign genbits_ready_o = enable_i & ~buf_valid_q;
  assign w_handshake     = genbits_valid_i & genbits_ready_o;
  // ~ack_q forces a gap cycle so the consumer can drop a registered request.
  assign w_ack_d         = enable_i & edn_i.edn_req & buf_valid_q & ~ack_q;

  always_comb begin
    buf_d       = buf_q;
    fips_d      = fips_q;
    buf_valid_d = buf_valid_q;
    idx_d       = idx_q;
    bus_d       = '0;    // entropy only lives on the bus for the ack cycle
    bus_fips_d  = 1'b0;
    cnt_d       = cnt_q;

    if (!enable_i) begin
      buf_d       = '0;
      fips_d      = 1'b0;
      buf_valid_d = 1'b0;
      idx_d       = 2'd0;
    end else begin
      // Handshake needs an empty buffer, ack needs a full one: never both.
      if (w_handshake) begin
        buf_d       = genbits_i;
        fips_d      = genbits_fips_i;
        buf_valid_d = 1'b1;
        idx_d       = 2'd0;
      end
      if (w_ack_d) begin
        bus_d      = buf_q[{idx_q, 5'b00000} +: ENDPOINT_BUS_WIDTH];
        bus_fips_d = fips_q;
        if (cnt_q != {CntWidth{1'b1}}) begin
          cnt_d = cnt_q + CntOne;
        end
        if (idx_q == 2'd3) begin
          buf_d       = '0;
          fips_d      = 1'b0;
          buf_valid_d = 1'b0;
          idx_d       = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q       <= '0;
      fips_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      idx_q       <= 2'd0;
      ack_q       <= 1'b0;
      bus_q       <= '0;
      bus_fips_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      buf_q       <= buf_d;
      fips_q      <= fips_d;
      buf_valid_q <= buf_valid_d;
      idx_q       <= idx_d;
      ack_q       <= w_ack_d;
      bus_q       <= bus_d;
      bus_fips_q  <= bus_fips_d;
      cnt_q       <= cnt_d;
    end
  end

  assign edn_o.edn_ack  = ack_q;
  assign edn_o.edn_fips = ack_q & bus_fips_q;
  assign edn_o.edn_bus  = ack_q ? bus_q : '0;
  assign words_served_o = cnt_q;

endmodule
